// File: rtl/instr_align_queue.sv
// rtl/instr_align_queue.sv - fetch-to-decode parcel alignment queue; define INSTR_ALIGN_COMPRESS_EN for 16/32-bit parcel alignment
module instr_align_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic [PC_W-1:0] clear_pc,
   input  logic            f_valid,
   output logic            f_ready,
   input  logic [PC_W-1:0] f_pc,
   input  logic [31:0]     f_instr,
   input  logic            f_error,
   output logic            d_valid,
   input  logic            d_ready,
   output logic [PC_W-1:0] d_pc,
   output logic [PC_W-1:0] d_npc,
   output logic [31:0]     d_instr,
   output logic            d_compressed,
   output logic            d_error
);

   localparam int AW  = $clog2(DEPTH);
   localparam int AW1 = AW + 1;
   localparam logic [AW:0] DEPTH_CNT = AW1'(DEPTH);
   localparam logic [AW:0] ONE_CNT   = AW1'(1);
   localparam logic [AW:0] TWO_CNT   = AW1'(2);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [15:0]     parcel_mem [DEPTH];
   logic [DEPTH-1:0] err_mem;
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [PC_W-1:0] head_pc;

   logic [AW:0]     count;
   logic            full;
   logic            empty;
   logic [AW-1:0]   rd_idx;
   logic [AW-1:0]   rd_idx_nxt;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   wr_idx_nxt;
   logic [15:0]     head_parcel;
   logic [15:0]     next_parcel;
   logic            head_err;
   logic            next_err;
   logic            head_short;
   logic            avail;
   logic [AW:0]     rd_step;
   logic            wr_one;
   logic            wr_en;
   logic            rd_en;
   logic            unused_pc_bits;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == DEPTH_CNT);

   // Two free entries are needed so an aligned word can always be taken whole.
   assign f_ready = !full && (count != DEPTH_CNT - ONE_CNT);

   assign rd_idx      = rd_ptr[AW-1:0];
   assign rd_idx_nxt  = rd_idx + 1'b1;
   assign wr_idx      = wr_ptr[AW-1:0];
   assign wr_idx_nxt  = wr_idx + 1'b1;
   assign head_parcel = parcel_mem[rd_idx];
   assign next_parcel = parcel_mem[rd_idx_nxt];
   assign head_err    = err_mem[rd_idx];
   assign next_err    = err_mem[rd_idx_nxt];
   assign d_pc        = head_pc;

   assign unused_pc_bits = ^f_pc;

`ifdef INSTR_ALIGN_COMPRESS_EN
   // A faulting head parcel is released alone so decode can trap without waiting.
   assign head_short = (head_parcel[1:0] != 2'b11) || head_err;
   assign avail      = (!empty && head_short) || (count >= TWO_CNT);
   assign wr_one     = f_pc[1];
`else
   assign head_short = 1'b0;
   assign avail      = (count >= TWO_CNT);
   assign wr_one     = 1'b0;
`endif

   always_comb begin
      d_valid      = 1'b0;
      d_instr      = NOP_INSTR;
      d_compressed = 1'b0;
      d_error      = 1'b0;
      d_npc        = head_pc;
      rd_step      = '0;
      if (avail) begin
         d_valid = 1'b1;
         if (head_short) begin
            d_instr      = {16'h0000, head_parcel};
            d_compressed = 1'b1;
            d_error      = head_err;
            d_npc        = head_pc + PC_W'(2);
            rd_step      = ONE_CNT;
         end else begin
            d_instr      = {next_parcel, head_parcel};
            d_compressed = 1'b0;
            d_error      = head_err | next_err;
            d_npc        = head_pc + PC_W'(4);
            rd_step      = TWO_CNT;
         end
      end
   end

   assign wr_en = f_valid && f_ready && !clear;
   assign rd_en = d_valid && d_ready && !clear;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         head_pc <= '0;
         err_mem <= '0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         head_pc <= clear_pc;
      end else begin
         if (wr_en) begin
            if (wr_one) begin
               parcel_mem[wr_idx] <= f_instr[31:16];
               err_mem[wr_idx]    <= f_error;
               wr_ptr             <= wr_ptr + ONE_CNT;
            end else begin
               parcel_mem[wr_idx]     <= f_instr[15:0];
               err_mem[wr_idx]        <= f_error;
               parcel_mem[wr_idx_nxt] <= f_instr[31:16];
               err_mem[wr_idx_nxt]    <= f_error;
               wr_ptr                 <= wr_ptr + TWO_CNT;
            end
         end
         if (rd_en) begin
            rd_ptr  <= rd_ptr + rd_step;
            head_pc <= d_npc;
         end
      end
   end

endmodule
